// File: rtl/alu_result_serializer.sv
// ALU result serializer: buffers {short, carry, res} words and emits 2/3-byte frames.
// Ports: res_valid/res_ready/res_q/carry_q/short_mode in, byte_out/valid/ready/last out, busy.
module alu_result_serializer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [17:0] res_q,
  input  logic        carry_q,
  input  logic        short_mode,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        byte_last,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_B0   = 2'd1;
  localparam logic [1:0] S_B1   = 2'd2;
  localparam logic [1:0] S_B2   = 2'd3;

  typedef struct packed {
    logic        short_f;
    logic        carry;
    logic [17:0] res;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          frame;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [1:0]      state;
  logic [1:0]      state_nxt;

  logic            push;
  logic            pop;
  logic            xfer;
  logic            frame_end;
  logic            fifo_empty;

  // res_ready looks only at the registered count, so a pop in the
  // same cycle never opens a slot early.
  assign res_ready  = (count < FULL);
  assign fifo_empty = (count == '0);
  assign push       = res_valid & res_ready;
  assign xfer       = byte_valid & byte_ready;

  assign frame_end  = xfer &
                      (((state == S_B1) & frame.short_f) |
                       (state == S_B2));

  // Pop when idle, or at end of frame so the next frame starts
  // without an idle bubble.
  assign pop = ~fifo_empty &
               ((state == S_IDLE) | frame_end);

  assign busy = (state != S_IDLE) | ~fifo_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{short_f: short_mode,
                       carry:   carry_q,
                       res:     res_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame <= '0;
    end else if (pop) begin
      frame <= mem[rd_ptr];
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (!fifo_empty) state_nxt = S_B0;
      end
      S_B0: begin
        if (xfer) state_nxt = S_B1;
      end
      S_B1: begin
        if (xfer) begin
          if (frame.short_f)
            state_nxt = fifo_empty ? S_IDLE : S_B0;
          else
            state_nxt = S_B2;
        end
      end
      S_B2: begin
        if (xfer)
          state_nxt = fifo_empty ? S_IDLE : S_B0;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs decode straight from state and the frame register, so they
  // hold for as long as the state does during a stall.
  always_comb begin
    byte_out   = 8'h00;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    unique case (state)
      S_IDLE: begin
        byte_out   = 8'h00;
      end
      S_B0: begin
        byte_valid = 1'b1;
        byte_out   = frame.res[7:0];
      end
      S_B1: begin
        byte_valid = 1'b1;
        byte_out   = frame.res[15:8];
        byte_last  = frame.short_f;
      end
      S_B2: begin
        byte_valid = 1'b1;
        byte_out   = {frame.carry, 5'b0, frame.res[17:16]};
        byte_last  = 1'b1;
      end
      default: begin
        byte_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed bench for alu_result_serializer.
// Drives/samples on the falling edge; expected bytes are hand-computed.
module tb_alu_result_serializer;

  logic        clk;
  logic        rst_n;
  logic        res_valid;
  logic        res_ready;
  logic [17:0] res_q;
  logic        carry_q;
  logic        short_mode;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        byte_last;
  logic        busy;

  int vectors;
  int miscompares;

  alu_result_serializer #(.DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_q      (res_q),
    .carry_q    (carry_q),
    .short_mode (short_mode),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_last  (byte_last),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (byte_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid got %b exp 0", byte_valid);
    end
    vectors++;
    if (byte_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_out got %h exp 00", byte_out);
    end
    vectors++;
    if (byte_last !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_last got %b exp 0", byte_last);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy got %b exp 0", busy);
    end
    vectors++;
    if (res_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready got %b exp 1", res_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pushed on the first edge after reset release.
  task automatic test_long_frame;
    logic [7:0] eo [4];
    logic       ev [4];
    logic       el [4];
    eo = '{8'hCD, 8'hAB, 8'h82, 8'h00};
    ev = '{1'b1, 1'b1, 1'b1, 1'b0};
    el = '{1'b0, 1'b0, 1'b1, 1'b0};
    res_q      = 18'h2ABCD;
    carry_q    = 1'b1;
    short_mode = 1'b0;
    byte_ready = 1'b1;
    res_valid  = 1'b1;
    vectors++;
    if (res_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL long_ready got %b exp 1", res_ready);
    end
    @(negedge clk);
    res_valid = 1'b0;
    vectors++;
    if (byte_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL long_latency valid/busy got %b/%b exp 0/1",
               byte_valid, busy);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (byte_valid !== ev[i] || byte_out !== eo[i] ||
          byte_last !== el[i]) begin
        miscompares++;
        $display("FAIL long_byte%0d got %b/%h/%b exp %b/%h/%b", i,
                 byte_valid, byte_out, byte_last, ev[i], eo[i], el[i]);
      end
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL long_idle_busy got %b exp 0", busy);
    end
  endtask

  task automatic test_short_frame;
    logic [7:0] eo [3];
    logic       ev [3];
    logic       el [3];
    eo = '{8'h34, 8'h12, 8'h00};
    ev = '{1'b1, 1'b1, 1'b0};
    el = '{1'b0, 1'b1, 1'b0};
    res_q      = 18'h01234;
    carry_q    = 1'b0;
    short_mode = 1'b1;
    byte_ready = 1'b1;
    res_valid  = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (byte_valid !== ev[i] || byte_out !== eo[i] ||
          byte_last !== el[i]) begin
        miscompares++;
        $display("FAIL short_byte%0d got %b/%h/%b exp %b/%h/%b", i,
                 byte_valid, byte_out, byte_last, ev[i], eo[i], el[i]);
      end
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL short_idle_busy got %b exp 0", busy);
    end
  endtask

  task automatic test_stall;
    res_q      = 18'h2ABCD;
    carry_q    = 1'b1;
    short_mode = 1'b0;
    byte_ready = 1'b1;
    res_valid  = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (byte_out !== 8'hCD) begin
      miscompares++;
      $display("FAIL stall_b0 got %h exp cd", byte_out);
    end
    @(negedge clk);
    byte_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (byte_valid !== 1'b1 || byte_out !== 8'hAB ||
          byte_last !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold%0d got %b/%h/%b exp 1/ab/0", i,
                 byte_valid, byte_out, byte_last);
      end
    end
    byte_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (byte_valid !== 1'b1 || byte_out !== 8'h82 ||
        byte_last !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_resume got %b/%h/%b exp 1/82/1",
               byte_valid, byte_out, byte_last);
    end
    @(negedge clk);
    vectors++;
    if (byte_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_idle got %b/%b exp 0/0", byte_valid, busy);
    end
  endtask

  task automatic test_fill;
    logic [17:0] vals [3];
    logic [7:0]  eo [5];
    logic        ev [5];
    logic        el [5];
    int          acc;
    vals = '{18'h01122, 18'h03344, 18'h05566};
    eo = '{8'h44, 8'h33, 8'h66, 8'h55, 8'h00};
    ev = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    el = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    acc        = 0;
    byte_ready = 1'b0;
    short_mode = 1'b1;
    carry_q    = 1'b0;
    res_valid  = 1'b1;
    res_q      = vals[0];
    for (int i = 0; i < 8; i++) begin
      if (res_ready) acc++;
      @(negedge clk);
      if (acc < 3) res_q = vals[acc];
    end
    res_valid = 1'b0;
    vectors++;
    if (acc !== 3) begin
      miscompares++;
      $display("FAIL fill_accepts got %0d exp 3", acc);
    end
    vectors++;
    if (res_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_full ready/busy got %b/%b exp 0/1",
               res_ready, busy);
    end
    vectors++;
    if (byte_valid !== 1'b1 || byte_out !== 8'h22) begin
      miscompares++;
      $display("FAIL fill_head got %b/%h exp 1/22", byte_valid, byte_out);
    end
    byte_ready = 1'b1;
    @(negedge clk);
    byte_ready = 1'b0;
    vectors++;
    if (byte_out !== 8'h11 || byte_last !== 1'b1 ||
        res_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_b1 got %h/%b/%b exp 11/1/0",
               byte_out, byte_last, res_ready);
    end
    @(negedge clk);
    vectors++;
    if (res_ready !== 1'b0 || byte_out !== 8'h11) begin
      miscompares++;
      $display("FAIL fill_noslot got %b/%h exp 0/11", res_ready, byte_out);
    end
    byte_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (res_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_slot_freed got %b exp 1", res_ready);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      vectors++;
      if (byte_valid !== ev[i] || byte_out !== eo[i] ||
          byte_last !== el[i]) begin
        miscompares++;
        $display("FAIL fill_drain%0d got %b/%h/%b exp %b/%h/%b", i,
                 byte_valid, byte_out, byte_last, ev[i], eo[i], el[i]);
      end
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_idle_busy got %b exp 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] eo [8];
    logic       ev [8];
    logic       el [8];
    eo = '{8'h00, 8'hCD, 8'hAB, 8'h82, 8'h0E, 8'hF0, 8'h01, 8'h00};
    ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    el = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    res_q      = 18'h2ABCD;
    carry_q    = 1'b1;
    short_mode = 1'b0;
    byte_ready = 1'b1;
    res_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        res_q   = 18'h1F00E;
        carry_q = 1'b0;
      end
      if (i == 1) res_valid = 1'b0;
      vectors++;
      if (byte_valid !== ev[i] || byte_out !== eo[i] ||
          byte_last !== el[i]) begin
        miscompares++;
        $display("FAIL b2b_cyc%0d got %b/%h/%b exp %b/%h/%b", i,
                 byte_valid, byte_out, byte_last, ev[i], eo[i], el[i]);
      end
    end
  endtask

  task automatic test_mid_reset;
    res_q      = 18'h2ABCD;
    carry_q    = 1'b1;
    short_mode = 1'b0;
    byte_ready = 1'b1;
    res_valid  = 1'b1;
    @(negedge clk);
    res_q = 18'h12345;
    @(negedge clk);
    res_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (byte_out !== 8'hAB || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mrst_b1 got %h/%b exp ab/1", byte_out, busy);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (byte_valid !== 1'b0 || byte_out !== 8'h00 ||
        byte_last !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mrst_async got %b/%h/%b/%b exp 0/00/0/0",
               byte_valid, byte_out, byte_last, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if (res_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mrst_ready got %b exp 1", res_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (byte_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL mrst_residual%0d got %b/%b exp 0/0",
                 i, byte_valid, busy);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    res_valid   = 1'b0;
    res_q       = '0;
    carry_q     = 1'b0;
    short_mode  = 1'b0;
    byte_ready  = 1'b0;
    test_reset;
    test_long_frame;
    test_short_frame;
    test_stall;
    test_fill;
    test_back_to_back;
    test_mid_reset;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
